// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions.
// Fetch FSM states, NOP encoding and decoder opcodes.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Clear the byte offset so every fetch address is word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instr_fetch_flopenr.sv
// Enable-gated register with a synchronous reset value.
// Used for the instr, pc, pc_plus4 and imem_addr registers.
module flopenr #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load on enable, reset wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, one-outstanding imem read,
// valid/ready output to decode, redirect with squash.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        redirect,
    input  logic [31:0] redirect_target
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic        r_squash;
    logic        w_squash_next;
    logic [31:0] r_target;
    logic [31:0] w_target_next;
    logic        r_req;
    logic        r_valid;

    logic        w_addr_en;
    logic [31:0] w_addr_d;
    logic        w_cap_en;
    logic [31:0] w_tgt;
    logic [31:0] w_addr_plus4;

    logic [31:0] r_addr;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_pc_plus4;

    assign w_tgt        = align_word(redirect_target);
    assign w_addr_plus4 = r_addr + 32'd4;

    flopenr #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_addr (
        .clk   (clk),
        .reset (reset),
        .en    (w_addr_en),
        .d     (w_addr_d),
        .q     (r_addr)
    );

    flopenr #(.WIDTH(32), .RESET_VAL(NOP_INSTR)) u_instr (
        .clk   (clk),
        .reset (reset),
        .en    (w_cap_en),
        .d     (imem_rdata),
        .q     (r_instr)
    );

    flopenr #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_pc (
        .clk   (clk),
        .reset (reset),
        .en    (w_cap_en),
        .d     (r_addr),
        .q     (r_pc)
    );

    flopenr #(.WIDTH(32), .RESET_VAL(RESET_PC + 32'd4)) u_pc_plus4 (
        .clk   (clk),
        .reset (reset),
        .en    (w_cap_en),
        .d     (w_addr_plus4),
        .q     (r_pc_plus4)
    );

    // State, squash bookkeeping and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_squash <= 1'b0;
            r_target <= RESET_PC;
            r_req    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_squash <= w_squash_next;
            r_target <= w_target_next;
            r_req    <= (w_state_next == REQ);
            r_valid  <= (w_state_next == HOLD);
        end
    end

    // Next state, address update, capture and redirect handling.
    always_comb begin
        w_state_next  = r_state;
        w_squash_next = r_squash;
        w_target_next = r_target;
        w_addr_en     = 1'b0;
        w_addr_d      = r_addr;
        w_cap_en      = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_state_next  = REQ;
                w_squash_next = 1'b0;
                if (redirect) begin
                    w_addr_en = 1'b1;
                    w_addr_d  = w_tgt;
                end
            end
            REQ: begin
                // Address must stay put until granted.
                if (redirect) begin
                    w_target_next = w_tgt;
                    w_squash_next = 1'b1;
                end
                if (imem_gnt) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    w_target_next = w_tgt;
                    w_squash_next = 1'b1;
                    if (imem_rvalid) begin
                        w_squash_next = 1'b0;
                        w_addr_en     = 1'b1;
                        w_addr_d      = w_tgt;
                        w_state_next  = REQ;
                    end
                end else if (imem_rvalid) begin
                    if (r_squash) begin
                        w_squash_next = 1'b0;
                        w_addr_en     = 1'b1;
                        w_addr_d      = r_target;
                        w_state_next  = REQ;
                    end else begin
                        w_cap_en     = 1'b1;
                        w_state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                // Redirect drops the held instruction even if consumed.
                if (redirect) begin
                    w_addr_en    = 1'b1;
                    w_addr_d     = w_tgt;
                    w_state_next = REQ;
                end else if (instr_ready) begin
                    w_addr_en    = 1'b1;
                    w_addr_d     = r_pc_plus4;
                    w_state_next = REQ;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign pc          = r_pc;
    assign pc_plus4    = r_pc_plus4;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: per-cycle vector table
// plus hand-written IDLE redirect and throughput sequence.
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic [31:0] redirect_target;

    int checks;
    int failures;

    instr_fetch #(.RESET_PC(32'h0000_1000)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .redirect        (redirect),
        .redirect_target (redirect_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        redir;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(
        input logic rst, input logic gnt, input logic rv,
        input logic [31:0] rdata, input logic rdy,
        input logic redir, input logic [31:0] tgt,
        input logic e_req, input logic [31:0] e_addr,
        input logic e_valid, input logic [31:0] e_instr,
        input logic [31:0] e_pc);
        vec_t v;
        v.rst = rst; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.rdy = rdy; v.redir = redir; v.tgt = tgt;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_pc = e_pc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%h expected=%h",
                     name, idx, act, exp);
        end
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I0  = 32'h0050_0093;
    localparam logic [31:0] I1  = 32'h00A0_0113;
    localparam logic [31:0] I2  = 32'h00C0_006F;
    localparam logic [31:0] I3  = 32'h1111_1013;
    localparam logic [31:0] I4  = 32'h2222_2013;
    localparam logic [31:0] I5  = 32'h3333_3013;

    initial begin
        logic        granted;
        logic [31:0] exp_pc;
        int          delivered;

        checks = 0;
        failures = 0;
        reset = 1'b1;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        instr_ready = 1'b0;
        redirect = 1'b0;
        redirect_target = '0;

        //  rst g rv rdata         rdy rd tgt            req addr          v  instr pc
        add(1, 0, 0, 0,            0, 0, 0,             0, 32'h1000,      0, NOP, 32'h1000);
        add(0, 0, 0, 0,            0, 0, 0,             0, 32'h1000,      0, NOP, 32'h1000);
        add(0, 1, 0, 0,            0, 0, 0,             1, 32'h1000,      0, NOP, 32'h1000);
        add(0, 0, 1, I0,           0, 0, 0,             0, 32'h1000,      0, NOP, 32'h1000);
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, 0,        0, 0, 0,             0, 32'h1000,      1, I0,  32'h1000);
        add(0, 0, 0, 0,            1, 0, 0,             0, 32'h1000,      1, I0,  32'h1000);
        for (int i = 0; i < 3; i++)
            add(0, 0, 0, 0,        0, 0, 0,             1, 32'h1004,      0, I0,  32'h1000);
        add(0, 1, 0, 0,            0, 0, 0,             1, 32'h1004,      0, I0,  32'h1000);
        for (int i = 0; i < 4; i++)
            add(0, 0, 0, 0,        0, 0, 0,             0, 32'h1004,      0, I0,  32'h1000);
        add(0, 0, 1, I1,           0, 0, 0,             0, 32'h1004,      0, I0,  32'h1000);
        add(0, 0, 0, 0,            1, 0, 0,             0, 32'h1004,      1, I1,  32'h1004);
        add(0, 1, 0, 0,            0, 0, 0,             1, 32'h1008,      0, I1,  32'h1004);
        add(0, 0, 0, 0,            0, 1, 32'h2002,      0, 32'h1008,      0, I1,  32'h1004);
        add(0, 0, 1, 32'hDEADBEEF, 0, 0, 0,             0, 32'h1008,      0, I1,  32'h1004);
        add(0, 1, 0, 0,            0, 0, 0,             1, 32'h2000,      0, I1,  32'h1004);
        add(0, 0, 1, I2,           0, 0, 0,             0, 32'h2000,      0, I1,  32'h1004);
        add(0, 0, 0, 0,            1, 1, 32'h3000,      0, 32'h2000,      1, I2,  32'h2000);
        add(0, 1, 0, 0,            0, 0, 0,             1, 32'h3000,      0, I2,  32'h2000);
        add(0, 0, 1, I3,           0, 0, 0,             0, 32'h3000,      0, I2,  32'h2000);
        add(0, 0, 0, 0,            1, 0, 0,             0, 32'h3000,      1, I3,  32'h3000);
        add(0, 0, 0, 0,            0, 1, 32'h4000,      1, 32'h3004,      0, I3,  32'h3000);
        add(0, 1, 0, 0,            0, 0, 0,             1, 32'h3004,      0, I3,  32'h3000);
        add(0, 0, 1, 32'hBADBAD13, 0, 0, 0,             0, 32'h3004,      0, I3,  32'h3000);
        add(0, 1, 0, 0,            0, 0, 0,             1, 32'h4000,      0, I3,  32'h3000);
        add(0, 0, 1, 32'h5555_5013,0, 1, 32'hFFFF_FFFE, 0, 32'h4000,      0, I3,  32'h3000);
        add(0, 1, 0, 0,            0, 0, 0,             1, 32'hFFFF_FFFC, 0, I3,  32'h3000);
        add(0, 0, 1, I4,           0, 0, 0,             0, 32'hFFFF_FFFC, 0, I3,  32'h3000);
        add(0, 0, 0, 0,            1, 0, 0,             0, 32'hFFFF_FFFC, 1, I4,  32'hFFFF_FFFC);
        add(0, 1, 0, 0,            0, 0, 0,             1, 32'h0000_0000, 0, I4,  32'hFFFF_FFFC);
        add(1, 0, 0, 0,            0, 0, 0,             0, 32'h0000_0000, 0, I4,  32'hFFFF_FFFC);
        add(0, 0, 1, 32'hEEEE_EEEE,0, 0, 0,             0, 32'h1000,      0, NOP, 32'h1000);
        add(0, 0, 0, 0,            0, 0, 0,             1, 32'h1000,      0, NOP, 32'h1000);
        add(0, 1, 0, 0,            0, 0, 0,             1, 32'h1000,      0, NOP, 32'h1000);
        add(0, 0, 1, I5,           0, 0, 0,             0, 32'h1000,      0, NOP, 32'h1000);
        add(0, 0, 0, 0,            0, 0, 0,             0, 32'h1000,      1, I5,  32'h1000);

        @(posedge clk);
        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst;
            imem_gnt = vecs[i].gnt;
            imem_rvalid = vecs[i].rv;
            imem_rdata = vecs[i].rdata;
            instr_ready = vecs[i].rdy;
            redirect = vecs[i].redir;
            redirect_target = vecs[i].tgt;
            #1;
            chk("imem_req", i, {31'd0, imem_req}, {31'd0, vecs[i].e_req});
            chk("imem_addr", i, imem_addr, vecs[i].e_addr);
            chk("instr_valid", i, {31'd0, instr_valid},
                {31'd0, vecs[i].e_valid});
            chk("instr", i, instr, vecs[i].e_instr);
            chk("pc", i, pc, vecs[i].e_pc);
            chk("pc_plus4", i, pc_plus4, vecs[i].e_pc + 32'd4);
        end

        // Redirect taken directly from IDLE.
        @(negedge clk);
        reset = 1'b1;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
        redirect = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        redirect = 1'b1;
        redirect_target = 32'h0000_5001;
        #1;
        chk("idle_req", 100, {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("idle_redir_req", 101, {31'd0, imem_req}, 32'd1);
        chk("idle_redir_addr", 101, imem_addr, 32'h0000_5000);

        // Zero-wait memory, ready tied high: one instr per 3 cycles.
        granted = 1'b0;
        exp_pc = 32'h0000_5000;
        delivered = 0;
        instr_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            imem_gnt = imem_req;
            imem_rvalid = granted;
            imem_rdata = NOP;
            granted = imem_req;
            if (instr_valid) begin
                chk("tput_pc", 200 + i, pc, exp_pc);
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
        end
        chk("tput_count", 300, delivered, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
